rc4_ksa_engine: RTL and testbench

- Self-sequenced RC4 key-scheduling engine: optionally initialises S[i]=i, then runs the full swap loop j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i]/S[j] over the whole S memory.
- Drives a single-port synchronous S RAM directly.
- Generalises the existing hand-sequenced shuffle datapath with its own FSM, a start/done handshake, parametrised key length, depth and RAM read latency, and an optional init phase.
- Sits between the top-level decrypt controller and the S RAM.

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/rc4_key_byte_sel.sv | 51 +++++
 rtl/rc4_ksa_engine.sv | 165 ++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling engine.
//   rc4_state_e : engine FSM states.
//   iter_cycles : cycles per swap-loop iteration for a given RAM read latency.
package rc4_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRdI,
    StSum,
    StRdJ,
    StWrI,
    StWrJ,
    StDone
  } rc4_state_e;

  // RD_I and RD_J each hold for rd_latency+1 cycles; SUM, WR_I and WR_J take one each.
  function automatic int unsigned iter_cycles(input int unsigned rd_latency);
    return 2 * (rd_latency + 1) + 3;
  endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Key byte selector for the RC4 key schedule.
// Holds the key index (which wraps after KEY_BYTES-1) and muxes the selected
// byte out of the latched key.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the index to 0
//   advance    : step the index, wrapping to 0 after KEY_BYTES-1
//   key        : latched key, byte k = key[8k+7:8k]
//   key_byte   : byte selected by the current index
module rc4_key_byte_sel #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic [7:0]             key_byte
);

  localparam int unsigned IdxW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(KEY_BYTES - 1);

  logic [IdxW-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (advance) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (idx_q == IdxW'(k)) begin
        key_byte = key[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// Self-sequenced RC4 key-scheduling engine driving a single-port synchronous S RAM.
// Optionally fills S[i]=i, then runs j = j + S[i] + key[i mod KEY_BYTES] with a
// swap of S[i]/S[j] for every i in 0..2**ADDR_W-1.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a run (only honoured in IDLE)
//   init_en    : run the S[i]=i fill before the swap loop (sampled with start)
//   key        : key bytes, sampled with start
//   mem_rdata  : S RAM read data, valid RD_LATENCY cycles after the address
//   mem_addr   : S RAM address
//   mem_wdata  : S RAM write data
//   mem_wr_en  : S RAM write enable
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse after the last swap
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES  = 3,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [7:0]             mem_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_wr_en,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CntW = $clog2(RD_LATENCY + 1);
  localparam logic [CntW-1:0] RdLast = CntW'(RD_LATENCY);
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  rc4_state_e state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             sj_q, sj_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;
  logic                   key_clear, key_advance;
  logic [7:0]             key_byte;

  rc4_key_byte_sel #(
    .KEY_BYTES(KEY_BYTES)
  ) u_key_sel (
    .clk      (clk),
    .reset    (reset),
    .clear    (key_clear),
    .advance  (key_advance),
    .key      (key_q),
    .key_byte (key_byte)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_clear   = 1'b0;
    key_advance = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wr_en   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          key_d     = key;
          i_d       = '0;
          j_d       = '0;
          cnt_d     = '0;
          key_clear = 1'b1;
          state_d   = init_en ? StInit : StRdI;
        end
      end
      StInit: begin
        mem_addr  = i_q;
        mem_wdata = 8'(i_q);
        mem_wr_en = 1'b1;
        i_d       = i_q + 1'b1;  // wraps to 0 after the last address
        if (i_q == LastAddr) begin
          state_d = StRdI;
        end
      end
      StRdI: begin
        mem_addr = i_q;
        if (cnt_q == RdLast) begin
          cnt_d   = '0;
          si_d    = mem_rdata;
          state_d = StSum;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSum: begin
        mem_addr = i_q;
        j_d      = j_q + ADDR_W'(si_q) + ADDR_W'(key_byte);
        state_d  = StRdJ;
      end
      StRdJ: begin
        mem_addr = j_q;
        if (cnt_q == RdLast) begin
          cnt_d   = '0;
          sj_d    = mem_rdata;
          state_d = StWrI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrI: begin
        mem_addr  = i_q;
        mem_wdata = sj_q;
        mem_wr_en = 1'b1;
        state_d   = StWrJ;
      end
      StWrJ: begin
        mem_addr    = j_q;
        mem_wdata   = si_q;
        mem_wr_en   = 1'b1;
        i_d         = i_q + 1'b1;
        key_advance = 1'b1;
        state_d     = (i_q == LastAddr) ? StDone : StRdI;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: a 4-entry instance (ADDR_W=2, KEY_BYTES=1) driven from a
// vector table and a default 256-entry instance for key rotation, handshake and
// mid-run reset. Each instance has its own RAM model; every RAM write is checked
// against a queue of writes predicted by a behavioural KSA model.
module tb_rc4_ksa_engine;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic        init;
    logic [7:0]  key;
    logic [31:0] pre;    // preload, byte a at [8a+:8]
    logic [31:0] fin;    // expected final RAM, same packing
    logic [31:0] lat;    // cycles from start to done
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  // small instance
  logic       start_s = 1'b0, init_s = 1'b0;
  logic [7:0] key_s = '0;
  logic [7:0] rdata_s;
  logic [1:0] addr_s;
  logic [7:0] wdata_s;
  logic       wr_s, busy_s, done_s;
  logic       pre_we = 1'b0;
  logic [1:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  logic [7:0] ram_s [4];

  // default instance
  logic        start_b = 1'b0, init_b = 1'b0;
  logic [23:0] key_b = '0;
  logic [7:0]  rdata_b;
  logic [7:0]  addr_b;
  logic [7:0]  wdata_b;
  logic        wr_b, busy_b, done_b;
  logic [7:0]  ram_b [256];

  rc4_ksa_engine #(
    .KEY_BYTES  (1),
    .ADDR_W     (2),
    .RD_LATENCY (1)
  ) u_dut_s (
    .clk       (clk),
    .reset     (reset),
    .start     (start_s),
    .init_en   (init_s),
    .key       (key_s),
    .mem_rdata (rdata_s),
    .mem_addr  (addr_s),
    .mem_wdata (wdata_s),
    .mem_wr_en (wr_s),
    .busy      (busy_s),
    .done      (done_s)
  );

  rc4_ksa_engine u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start_b),
    .init_en   (init_b),
    .key       (key_b),
    .mem_rdata (rdata_b),
    .mem_addr  (addr_b),
    .mem_wdata (wdata_b),
    .mem_wr_en (wr_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  always @(posedge clk) begin
    if (wr_s) ram_s[addr_s] <= wdata_s;
    else if (pre_we) ram_s[pre_addr] <= pre_data;
    rdata_s <= ram_s[addr_s];
  end

  always @(posedge clk) begin
    if (wr_b) ram_b[addr_b] <= wdata_b;
    rdata_b <= ram_b[addr_b];
  end

  int   errors = 0, checks = 0, cyc = 0;
  wr_t  q_s[$], q_b[$], log_b[$];
  int   done_cnt_s, done_cnt_b, done_cyc_s, done_cyc_b;
  int   jlog [256];
  logic [7:0] exp_s [256];
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, then sample DUT outputs on the falling edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (wr_s === 1'b1) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL small_wr_unexpected: addr=%0h data=%0h, no write expected", addr_s, wdata_s);
      end else begin
        e = q_s.pop_front();
        if ({6'd0, addr_s} !== e.addr || wdata_s !== e.data) begin
          errors++;
          $display("FAIL small_wr: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   addr_s, wdata_s, e.addr, e.data);
        end
      end
    end
    if (wr_b === 1'b1) begin
      log_b.push_back({addr_b, wdata_b});
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL big_wr_unexpected: addr=%0h data=%0h, no write expected", addr_b, wdata_b);
      end else begin
        e = q_b.pop_front();
        if (addr_b !== e.addr || wdata_b !== e.data) begin
          errors++;
          $display("FAIL big_wr: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   addr_b, wdata_b, e.addr, e.data);
        end
      end
    end
    if (done_s === 1'b1) begin
      done_cnt_s++;
      done_cyc_s = cyc;
    end
    if (done_b === 1'b1) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  endtask

  task automatic push_exp(input bit big, input int a, input int d);
    wr_t e;
    e.addr = 8'(a);
    e.data = 8'(d);
    if (big) q_b.push_back(e);
    else q_s.push_back(e);
  endtask

  // Reference KSA from the current RAM image; queues the expected write sequence.
  task automatic model_run(input bit big, input bit init_en, input logic [23:0] k);
    int n, kb, j;
    logic [7:0] s [256];
    logic [7:0] kbyte, t;
    n  = big ? 256 : 4;
    kb = big ? 3 : 1;
    for (int a = 0; a < n; a++) begin
      if (big) s[a] = ram_b[a];
      else s[a] = ram_s[a];
    end
    if (init_en) begin
      for (int a = 0; a < n; a++) begin
        s[a] = 8'(a);
        push_exp(big, a, a);
      end
    end
    j = 0;
    for (int i = 0; i < n; i++) begin
      kbyte = k[8*(i%kb) +: 8];
      j = (j + int'(s[i]) + int'(kbyte)) % n;
      jlog[i] = j;
      push_exp(big, i, s[j]);
      push_exp(big, j, s[i]);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int a = 0; a < n; a++) exp_s[a] = s[a];
  endtask

  task automatic run_small(input int v);
    int c0;
    for (int a = 0; a < 4; a++) begin
      pre_we = 1'b1; pre_addr = 2'(a); pre_data = vecs[v].pre[8*a +: 8];
      tick();
    end
    pre_we = 1'b0;
    model_run(1'b0, vecs[v].init, {16'd0, vecs[v].key});
    done_cnt_s = 0; done_cyc_s = -1;
    start_s = 1'b1; init_s = vecs[v].init; key_s = vecs[v].key;
    c0 = cyc;
    tick();
    start_s = 1'b0; init_s = ~init_s; key_s = 8'($urandom);
    if (vecs[v].init) check($sformatf("v%0d_first_init_wr", v), {wr_s, addr_s}, 3'b100);
    for (int t = 0; t < 100 && done_cnt_s == 0; t++) tick();
    check($sformatf("v%0d_done_latency", v), done_cyc_s - c0, vecs[v].lat);
    for (int t = 0; t < 5; t++) tick();
    check($sformatf("v%0d_done_count", v), done_cnt_s, 1);
    check($sformatf("v%0d_writes_left", v), q_s.size(), 0);
    for (int a = 0; a < 4; a++)
      check($sformatf("v%0d_ram[%0d]", v, a), ram_s[a], vecs[v].fin[8*a +: 8]);
    q_s.delete();
  endtask

  // Full default-size run; optional start/key disturbance mid-loop.
  task automatic run_big(input string tag, input logic [23:0] k, input bit perturb);
    int c0, mism;
    model_run(1'b1, 1'b1, k);
    log_b.delete();
    done_cnt_b = 0; done_cyc_b = -1;
    start_b = 1'b1; init_b = 1'b1; key_b = k;
    c0 = cyc;
    tick();
    start_b = 1'b0;
    for (int t = 0; t < 3000 && done_cnt_b == 0; t++) begin
      if (perturb && t == 1000) begin
        start_b = 1'b1; key_b = 24'hAABBCC; init_b = 1'b0;
      end else if (perturb && t == 1001) begin
        start_b = 1'b0; key_b = 24'h123456;
      end
      tick();
    end
    start_b = 1'b0;
    check({tag, "_done_latency"}, done_cyc_b - c0, 256 + 256 * 7 + 1);
    for (int t = 0; t < 10; t++) tick();
    check({tag, "_done_count"}, done_cnt_b, 1);
    check({tag, "_writes_left"}, q_b.size(), 0);
    mism = 0;
    for (int a = 0; a < 256; a++) if (ram_b[a] !== exp_s[a]) mism++;
    check({tag, "_final_ram_mismatches"}, mism, 0);
    q_b.delete();
  endtask

  initial begin
    int c0;
    //            init  key    preload       final         latency
    vecs[0] = '{1'b1, 8'h01, 32'h00000000, 32'h01030200, 33};
    vecs[1] = '{1'b0, 8'h00, 32'h03020100, 32'h01030200, 29};
    vecs[2] = '{1'b1, 8'h00, 32'hFFFFFFFF, 32'h01030200, 33};
    vecs[3] = '{1'b0, 8'h03, 32'h00010203, 32'h00020301, 29};

    for (int t = 0; t < 3; t++) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", {busy_s, busy_b}, 0);
    check("rst_done", {done_s, done_b}, 0);
    check("rst_wr_en", {wr_s, wr_b}, 0);
    check("rst_addr", {addr_s, addr_b}, 0);
    check("rst_wdata", {wdata_s, wdata_b}, 0);

    for (int v = 0; v < 4; v++) run_small(v);

    // Key rotation with a start/key disturbance that must be ignored.
    run_big("rot", 24'h030201, 1'b1);
    check("rot_first_wr_i", log_b[256], {8'd0, 8'd1});
    check("rot_first_wr_j", log_b[257], {8'd1, 8'd0});
    check("rot_j1", log_b[259].addr, 3);
    check("rot_j2", log_b[261].addr, 8);
    check("rot_j3", log_b[263].addr, 9);

    // Reset during RD_J of iteration 5.
    model_run(1'b1, 1'b1, 24'h5A17C3);
    start_b = 1'b1; init_b = 1'b1; key_b = 24'h5A17C3;
    c0 = cyc;
    tick();
    start_b = 1'b0;
    for (int t = 0; t < 400 && cyc < c0 + 295; t++) tick();
    check("rdj5_addr", addr_b, jlog[5]);
    check("rdj5_wr_en", wr_b, 0);
    check("rdj5_writes_left", q_b.size(), 768 - 266);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_b.delete();
    check("mid_rst_busy", busy_b, 0);
    check("mid_rst_outs", {done_b, wr_b, addr_b, wdata_b}, 0);
    for (int t = 0; t < 20; t++) tick();
    check("mid_rst_idle", busy_b, 0);

    run_big("post_rst", 24'hC0FFEE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
